// File: rtl/ir_tx_if.sv
// rtl/ir_tx_if.sv - request/line-output bundle between an NEC transmitter and its user
//
// Signals:
//   i_start, i_rpt, i_data : frame request from the user (master drives)
//   o_ir_tx, o_ir_env      : modulated LED drive and unmodulated envelope
//   o_busy, o_done         : frame-in-progress level and completion pulse
interface ir_tx_if;
    logic        i_start;
    logic        i_rpt;
    logic [31:0] i_data;
    logic        o_ir_tx;
    logic        o_ir_env;
    logic        o_busy;
    logic        o_done;

    modport master (
        output i_start, i_rpt, i_data,
        input  o_ir_tx, o_ir_env, o_busy, o_done
    );

    modport slave (
        input  i_start, i_rpt, i_data,
        output o_ir_tx, o_ir_env, o_busy, o_done
    );
endinterface

// File: rtl/ir_tx.sv
// rtl/ir_tx.sv - NEC infrared transmitter with 38 kHz carrier modulation
//
// Ports:
//   clk   : system clock (50 MHz on the board)
//   rst_n : asynchronous active-low reset
//   bus   : ir_tx_if.slave - start/repeat request, 32-bit frame word,
//           modulated output, envelope, busy level and done pulse
module ir_tx #(
    parameter int CLK_DIV      = 50,
    parameter int CARR_DIV     = 1316,
    parameter int T_LEAD_MARK  = 9000,
    parameter int T_LEAD_SPACE = 4500,
    parameter int T_RPT_SPACE  = 2250,
    parameter int T_BIT_MARK   = 560,
    parameter int T_ZERO_SPACE = 560,
    parameter int T_ONE_SPACE  = 1690
) (
    input  logic     clk,
    input  logic     rst_n,
    ir_tx_if.slave   bus
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max2(max2(max2(T_LEAD_MARK, T_LEAD_SPACE), max2(T_RPT_SPACE, T_BIT_MARK)),
                                max2(T_ZERO_SPACE, T_ONE_SPACE));
    localparam int PW = $clog2(CLK_DIV + 1);
    localparam int SW = $clog2(T_MAX + 1);
    localparam int CW = $clog2(CARR_DIV + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CARR_LAST  = CW'(CARR_DIV - 1);
    localparam logic [CW-1:0] CARR_HALF  = CW'(CARR_DIV / 2);

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        RPT_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] seg_q, seg_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic [31:0]   shreg_q, shreg_d;
    logic          rpt_q, rpt_d;
    logic [CW-1:0] carr_q, carr_d;
    logic          env_q, env_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [SW-1:0] seg_last;
    logic          seg_end;
    logic          accept;

    // Last tick index of the segment currently being timed.
    always_comb begin
        seg_last = '0;
        case (state_q)
            LEAD_MARK:  seg_last = SW'(T_LEAD_MARK - 1);
            LEAD_SPACE: seg_last = SW'(T_LEAD_SPACE - 1);
            RPT_SPACE:  seg_last = SW'(T_RPT_SPACE - 1);
            BIT_MARK:   seg_last = SW'(T_BIT_MARK - 1);
            BIT_SPACE:  seg_last = shreg_q[31] ? SW'(T_ONE_SPACE - 1) : SW'(T_ZERO_SPACE - 1);
            STOP_MARK:  seg_last = SW'(T_BIT_MARK - 1);
            default:    seg_last = '0;
        endcase
    end

    assign seg_end = (state_q != IDLE) && (presc_q == PRESC_LAST) && (seg_q == seg_last);

    // The done cycle is still IDLE but must not accept a new start.
    assign accept = (state_q == IDLE) && !done_q && bus.i_start;

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        seg_d     = seg_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        rpt_d     = rpt_q;
        done_d    = 1'b0;
        carr_d    = (carr_q == CARR_LAST) ? '0 : carr_q + 1'b1;

        if (state_q != IDLE) begin
            if (seg_end) begin
                presc_d = '0;
                seg_d   = '0;
            end else if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                seg_d   = seg_q + 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d   = bus.i_data;
                    rpt_d     = bus.i_rpt;
                    bit_cnt_d = '0;
                    presc_d   = '0;
                    seg_d     = '0;
                    carr_d    = '0;
                    state_d   = LEAD_MARK;
                end
            end
            LEAD_MARK: begin
                if (seg_end) state_d = rpt_q ? RPT_SPACE : LEAD_SPACE;
            end
            LEAD_SPACE: begin
                if (seg_end) state_d = BIT_MARK;
            end
            RPT_SPACE: begin
                if (seg_end) state_d = STOP_MARK;
            end
            BIT_MARK: begin
                if (seg_end) state_d = BIT_SPACE;
            end
            BIT_SPACE: begin
                if (seg_end) begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    shreg_d   = {shreg_q[30:0], 1'b0};
                    state_d   = (bit_cnt_q == 6'd31) ? STOP_MARK : BIT_MARK;
                end
            end
            STOP_MARK: begin
                if (seg_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        env_d  = (state_d == LEAD_MARK) || (state_d == BIT_MARK) || (state_d == STOP_MARK);
        busy_d = (state_d != IDLE);
        tx_d   = env_d && (carr_d < CARR_HALF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            seg_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            rpt_q     <= 1'b0;
            carr_q    <= '0;
            env_q     <= 1'b0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            seg_q     <= seg_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            rpt_q     <= rpt_d;
            carr_q    <= carr_d;
            env_q     <= env_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.o_ir_tx  = tx_q;
    assign bus.o_ir_env = env_q;
    assign bus.o_busy   = busy_q;
    assign bus.o_done   = done_q;

endmodule

// File: tb/tb_ir_tx.sv
// tb/tb_ir_tx.sv - self-checking bench for ir_tx with scaled-down timing
module tb_ir_tx;

    localparam int CLK_DIV      = 2;
    localparam int CARR_DIV     = 7;
    localparam int T_LEAD_MARK  = 17;
    localparam int T_LEAD_SPACE = 11;
    localparam int T_RPT_SPACE  = 7;
    localparam int T_BIT_MARK   = 3;
    localparam int T_ZERO_SPACE = 2;
    localparam int T_ONE_SPACE  = 5;
    localparam int LIMIT        = 4000;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    ir_tx_if bus ();

    ir_tx #(
        .CLK_DIV      (CLK_DIV),
        .CARR_DIV     (CARR_DIV),
        .T_LEAD_MARK  (T_LEAD_MARK),
        .T_LEAD_SPACE (T_LEAD_SPACE),
        .T_RPT_SPACE  (T_RPT_SPACE),
        .T_BIT_MARK   (T_BIT_MARK),
        .T_ZERO_SPACE (T_ZERO_SPACE),
        .T_ONE_SPACE  (T_ONE_SPACE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        rpt;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int frame_cycles(input logic [31:0] d, input logic r);
        int ones;
        ones = $countones(d);
        if (r) return CLK_DIV * (T_LEAD_MARK + T_RPT_SPACE + T_BIT_MARK);
        return CLK_DIV * (T_LEAD_MARK + T_LEAD_SPACE + T_BIT_MARK + 32 * T_BIT_MARK
                          + (32 - ones) * T_ZERO_SPACE + ones * T_ONE_SPACE);
    endfunction

    // Starts a frame, watches it to completion and compares it with the
    // envelope built from the NEC rules as a list of alternating run lengths.
    task automatic send_frame(input logic [31:0] d, input logic r, input int exp_cyc,
                              input int inj_bit, input bit poke_done);
        int          runs_exp[$];
        int          runs_obs[$];
        int          cur, k, tx_err, done_mid, run_err, inj_cycle;
        logic        prev_env;
        logic [31:0] dec;
        int          thr;

        runs_exp.push_back(T_LEAD_MARK * CLK_DIV);
        if (r) begin
            runs_exp.push_back(T_RPT_SPACE * CLK_DIV);
        end else begin
            runs_exp.push_back(T_LEAD_SPACE * CLK_DIV);
            for (int i = 31; i >= 0; i--) begin
                runs_exp.push_back(T_BIT_MARK * CLK_DIV);
                runs_exp.push_back((d[i] ? T_ONE_SPACE : T_ZERO_SPACE) * CLK_DIV);
            end
        end
        runs_exp.push_back(T_BIT_MARK * CLK_DIV);

        inj_cycle = -1;
        if (inj_bit >= 0) begin
            inj_cycle = 1;
            for (int i = 0; i < 2 + 2 * inj_bit; i++) inj_cycle += runs_exp[i];
        end

        bus.i_data  = d;
        bus.i_rpt   = r;
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        bus.i_data  = $urandom;
        bus.i_rpt   = ~r;
        check("busy_latency", 32'(bus.o_busy), 32'd1);
        check("env_latency", 32'(bus.o_ir_env), 32'd1);

        k = 0; cur = 0; prev_env = 1'b1; tx_err = 0; done_mid = 0;
        while (bus.o_busy && k < LIMIT) begin
            if (bus.o_ir_env !== prev_env) begin
                runs_obs.push_back(cur);
                cur = 0;
                prev_env = bus.o_ir_env;
            end
            cur++;
            if (bus.o_ir_tx !== (bus.o_ir_env && ((k % CARR_DIV) < CARR_DIV / 2))) tx_err++;
            if (bus.o_done) done_mid++;
            if (k == inj_cycle) begin
                bus.i_start = 1'b1;
                bus.i_data  = ~d;
                bus.i_rpt   = ~r;
            end else begin
                bus.i_start = 1'b0;
            end
            k++;
            step();
        end
        runs_obs.push_back(cur);

        check("busy_cycles", 32'(k), 32'(exp_cyc));
        check("done_at_end", 32'(bus.o_done), 32'd1);
        check("env_low_at_end", 32'(bus.o_ir_env), 32'd0);
        check("done_during_frame", 32'(done_mid), 32'd0);
        check("carrier_tx_errors", 32'(tx_err), 32'd0);

        run_err = (runs_obs.size() != runs_exp.size()) ? 1 : 0;
        if (run_err == 0)
            foreach (runs_exp[i]) if (runs_obs[i] != runs_exp[i]) run_err++;
        check("envelope_runs", 32'(run_err), 32'd0);

        if (!r && runs_obs.size() == 67) begin
            thr = (T_ZERO_SPACE + T_ONE_SPACE) * CLK_DIV / 2;
            dec = '0;
            for (int i = 0; i < 32; i++) dec = {dec[30:0], runs_obs[3 + 2 * i] > thr};
            check("decoded_word", dec, d);
        end

        if (poke_done) begin
            bus.i_start = 1'b1;
            bus.i_data  = ~d;
            bus.i_rpt   = ~r;
        end
        step();
        bus.i_start = 1'b0;
        check("done_one_cycle", 32'(bus.o_done), 32'd0);
        check("idle_after_done", 32'(bus.o_busy), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic        r;
        logic        done_seen;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{32'h0000_0000, 1'b0, 382};
        vecs[1] = '{32'hFFFF_0000, 1'b0, 478};
        vecs[2] = '{32'hFFFF_FFFF, 1'b0, 574};
        vecs[3] = '{32'hA5A5_A5A5, 1'b0, 478};
        vecs[4] = '{32'h8000_0001, 1'b0, 394};
        vecs[5] = '{32'h1234_5678, 1'b1, 54};

        rst_n       = 1'b0;
        bus.i_start = 1'b0;
        bus.i_rpt   = 1'b0;
        bus.i_data  = '0;
        repeat (3) step();
        check("reset_outputs", 32'({bus.o_ir_tx, bus.o_ir_env, bus.o_busy, bus.o_done}), 32'd0);
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) send_frame(vecs[i].data, vecs[i].rpt, vecs[i].exp_cycles, -1, 1'b0);

        // Starts at bit 10 and in the done cycle are ignored; the next one is taken.
        send_frame(32'h1234_5678, 1'b0, 460, 10, 1'b1);
        send_frame(32'hFFFF_0000, 1'b0, 478, -1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            r = ($urandom_range(0, 3) == 0);
            send_frame(d, r, frame_cycles(d, r), -1, 1'b0);
        end

        // Abort inside the first bit space.
        bus.i_data  = 32'hC0DE_0001;
        bus.i_rpt   = 1'b0;
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        repeat (64) step();
        check("in_bit_space", 32'({bus.o_busy, bus.o_ir_env}), 32'b10);
        rst_n = 1'b0;
        #2;
        check("async_reset_outputs", 32'({bus.o_ir_tx, bus.o_ir_env, bus.o_busy, bus.o_done}), 32'd0);
        done_seen = 1'b0;
        repeat (4) begin
            step();
            done_seen = done_seen | bus.o_done | bus.o_busy;
        end
        check("no_done_after_abort", 32'(done_seen), 32'd0);
        rst_n = 1'b1;
        step();
        send_frame(32'hA5A5_A5A5, 1'b0, 478, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
